isr_rotating_core: RTL and testbench
====================================

Name: isr_rotating_core

Overview:
- Parametrised, clocked in-service register (ISR) for the interrupt controller.
- Sits between the priority resolver and the control logic.
- Latches acknowledged interrupts and retires them by non-specific, specific or automatic end-of-interrupt (EOI).
- Owns the rotating-priority pointer, and reports the highest-priority in-service level under rotation and special mask.

Parameters:
- NUM_IRQ, 8, number of interrupt levels; power of two, 2..32.
- LEVEL_W, 3, level index width; equals log2(NUM_IRQ).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- latch_in_service  in  1  one-cycle pulse; OR the interrupt vector into the ISR.
- interrupt  in  NUM_IRQ  acknowledged request from the priority resolver; normally one-hot.
- eoi_cmd  in  2  00 none, 01 non-specific EOI, 10 specific EOI, 11 reserved (treated as none).
- eoi_level  in  LEVEL_W  target level for specific EOI.
- rotate_on_eoi  in  1  when set with an EOI, the retired level becomes lowest priority.
- set_priority  in  1  pulse; load the lowest-priority pointer from priority_level.
- priority_level  in  LEVEL_W  value for set_priority.
- auto_eoi_mode  in  1  level; enables automatic EOI.
- end_of_ack  in  1  pulse at the end of the acknowledge sequence.
- special_mask_mode  in  1  level; apply interrupt_special_mask to highest-level search.
- interrupt_special_mask  in  NUM_IRQ  1 = level masked from the search.
- in_service_register  out  NUM_IRQ  registered ISR.
- lowest_priority  out  LEVEL_W  registered rotation pointer.
- highest_level_in_service  out  NUM_IRQ  one-hot highest-priority in-service level; combinational from registered state.
- highest_level_id  out  LEVEL_W  binary index of the above; 0 when none.
- in_service_valid  out  1  1 when highest_level_in_service is nonzero.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - in_service_register=0.
  - lowest_priority=NUM_IRQ-1, so level 0 is highest priority.
  - last_latched (internal, NUM_IRQ)=0.
  - All derived outputs are 0.
  - Deassertion takes effect at the next rising clock edge.
- Priority order: highest priority is lowest_priority+1 mod NUM_IRQ, then increasing index with wrap. Level lowest_priority is last.
- Search vector S:
  - special_mask_mode=1: S = ISR & ~interrupt_special_mask.
  - special_mask_mode=0: S = ISR.
- highest_level_in_service = first set bit of S in priority order; 0 if S=0.
- Per rising edge, the next ISR is computed in this order, all from current registered values:
  1. Clear vector C (one of):
     - non-specific EOI: C = current highest_level_in_service.
     - specific EOI: C = one-hot(eoi_level).
     - auto_eoi_mode=1 and end_of_ack=1: C |= last_latched.
  2. ISR_next = (ISR & ~C) | (latch_in_service ? interrupt : 0).
     - Set wins over clear on the same bit.
  3. last_latched <= interrupt when latch_in_service=1; cleared to 0 when the auto-EOI clear fires.
- Latency:
  - ISR change is visible one cycle after the command edge.
  - highest_* outputs follow in the same cycle as the ISR change, with no extra delay.
- Rotation update, applied at the same edge:
  - set_priority=1: lowest_priority <= priority_level. This has top precedence.
  - else rotate_on_eoi=1 with an effective clear:
    - non-specific: lowest_priority <= highest_level_id.
    - specific: lowest_priority <= eoi_level.
    - auto-EOI: lowest_priority <= index of the lowest set bit of last_latched.
  - Non-specific EOI with in_service_valid=0: no clear, no rotation.
  - Specific EOI on a clear bit: no ISR change, but rotation still applies when rotate_on_eoi=1.
- Multiple simultaneous EOI sources (specific plus auto-EOI) union their clears. Rotation takes the eoi_cmd source.
- A non-one-hot interrupt vector latches all its bits. This is legal; last_latched holds all of them.
- eoi_cmd=11 behaves as 00.
- With NUM_IRQ=2, LEVEL_W=1, wrap arithmetic is still modulo NUM_IRQ.

Test Plan:
- Reset, then latch interrupt=0x08 -> ISR=0x08, highest_level_id=3, in_service_valid=1.
- ISR=0x0A, non-specific EOI with rotate_on_eoi=1 -> ISR=0x08, lowest_priority=1. Then highest_level_in_service=0x08.
- Set lowest_priority=4; ISR=0x21 -> highest_level_id=5. Enable special mask 0x20 -> highest_level_id=0.
- ISR=0x04; same cycle: latch 0x04 plus specific EOI level 2 -> ISR remains 0x04.
- auto_eoi_mode=1: latch 0x40, then end_of_ack with rotate_on_eoi=1 -> ISR bit 6 clear, lowest_priority=6. A later end_of_ack changes nothing.
- Assert reset_n=0 mid-cycle with ISR=0xFF and lowest_priority=2 -> all outputs 0 immediately and lowest_priority=7. Then latch 0x01 after release -> ISR=0x01.

Source files
------------

// File: rtl/isr_rotating_core.sv
// rtl/isr_rotating_core.sv - in-service register with rotating priority and EOI retirement
module isr_rotating_core #(
    parameter int NUM_IRQ = 8,
    parameter int LEVEL_W = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               latch_in_service,
    input  logic [NUM_IRQ-1:0] interrupt,
    input  logic [1:0]         eoi_cmd,
    input  logic [LEVEL_W-1:0] eoi_level,
    input  logic               rotate_on_eoi,
    input  logic               set_priority,
    input  logic [LEVEL_W-1:0] priority_level,
    input  logic               auto_eoi_mode,
    input  logic               end_of_ack,
    input  logic               special_mask_mode,
    input  logic [NUM_IRQ-1:0] interrupt_special_mask,
    output logic [NUM_IRQ-1:0] in_service_register,
    output logic [LEVEL_W-1:0] lowest_priority,
    output logic [NUM_IRQ-1:0] highest_level_in_service,
    output logic [LEVEL_W-1:0] highest_level_id,
    output logic               in_service_valid
);

    localparam logic [NUM_IRQ-1:0] ONE = {{(NUM_IRQ-1){1'b0}}, 1'b1};

    logic [NUM_IRQ-1:0] r_isr;
    logic [NUM_IRQ-1:0] r_last_latched;
    logic [LEVEL_W-1:0] r_lowest;

    logic [NUM_IRQ-1:0] w_search;
    logic [NUM_IRQ-1:0] w_highest;
    logic [LEVEL_W-1:0] w_highest_id;
    logic [LEVEL_W-1:0] w_pos;
    logic               w_found;
    logic [LEVEL_W-1:0] w_ll_low;
    logic               w_ns_fire;
    logic               w_spec_fire;
    logic               w_auto_fire;
    logic [NUM_IRQ-1:0] w_clear;
    logic [NUM_IRQ-1:0] w_isr_next;
    logic [NUM_IRQ-1:0] w_ll_next;
    logic [LEVEL_W-1:0] w_lowest_next;

    // Special mask hides levels from the search but never from the ISR itself
    always_comb begin
        w_search = special_mask_mode ? (r_isr & ~interrupt_special_mask) : r_isr;
    end

    // Walk levels starting just above the rotation pointer; index wraps by truncation
    always_comb begin
        w_highest    = '0;
        w_highest_id = '0;
        w_found      = 1'b0;
        w_pos        = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            w_pos = r_lowest + LEVEL_W'(k + 1);
            if (!w_found && w_search[w_pos]) begin
                w_highest[w_pos] = 1'b1;
                w_highest_id     = w_pos;
                w_found          = 1'b1;
            end
        end
    end

    // Lowest set bit of the auto-EOI candidate, used as its rotation target
    always_comb begin
        w_ll_low = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (r_last_latched[k]) begin
                w_ll_low = LEVEL_W'(k);
            end
        end
    end

    // Union of EOI clears, new latches on top, and the rotation pointer update
    always_comb begin
        w_ns_fire   = (eoi_cmd == 2'b01) && w_found;
        w_spec_fire = (eoi_cmd == 2'b10);
        // An empty auto-EOI candidate means there is nothing to retire or rotate to
        w_auto_fire = auto_eoi_mode && end_of_ack && (|r_last_latched);

        w_clear = '0;
        if (w_ns_fire) begin
            w_clear = w_clear | w_highest;
        end
        if (w_spec_fire) begin
            w_clear = w_clear | (ONE << eoi_level);
        end
        if (w_auto_fire) begin
            w_clear = w_clear | r_last_latched;
        end

        w_isr_next = (r_isr & ~w_clear) | (latch_in_service ? interrupt : '0);

        w_ll_next = r_last_latched;
        if (latch_in_service) begin
            w_ll_next = interrupt;
        end else if (w_auto_fire) begin
            w_ll_next = '0;
        end

        w_lowest_next = r_lowest;
        if (set_priority) begin
            w_lowest_next = priority_level;
        end else if (rotate_on_eoi) begin
            if (w_ns_fire) begin
                w_lowest_next = w_highest_id;
            end else if (w_spec_fire) begin
                w_lowest_next = eoi_level;
            end else if (w_auto_fire) begin
                w_lowest_next = w_ll_low;
            end
        end
    end

    // State registers; reset leaves level 0 as highest priority
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_isr          <= '0;
            r_last_latched <= '0;
            r_lowest       <= LEVEL_W'(NUM_IRQ - 1);
        end else begin
            r_isr          <= w_isr_next;
            r_last_latched <= w_ll_next;
            r_lowest       <= w_lowest_next;
        end
    end

    assign in_service_register      = r_isr;
    assign lowest_priority          = r_lowest;
    assign highest_level_in_service = w_highest;
    assign highest_level_id         = w_highest_id;
    assign in_service_valid         = w_found;

endmodule

// File: tb/tb_isr_rotating_core.sv
// tb/tb_isr_rotating_core.sv - vector table, reset corners and random model check for isr_rotating_core
module tb_isr_rotating_core;

    localparam int N = 8;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       latch_in_service;
    logic [7:0] interrupt;
    logic [1:0] eoi_cmd;
    logic [2:0] eoi_level;
    logic       rotate_on_eoi;
    logic       set_priority;
    logic [2:0] priority_level;
    logic       auto_eoi_mode;
    logic       end_of_ack;
    logic       special_mask_mode;
    logic [7:0] interrupt_special_mask;
    logic [7:0] in_service_register;
    logic [2:0] lowest_priority;
    logic [7:0] highest_level_in_service;
    logic [2:0] highest_level_id;
    logic       in_service_valid;

    int tests_run = 0;
    int tests_failed = 0;

    isr_rotating_core #(.NUM_IRQ(8), .LEVEL_W(3)) dut (
        .clock                    (clock),
        .reset_n                  (reset_n),
        .latch_in_service         (latch_in_service),
        .interrupt                (interrupt),
        .eoi_cmd                  (eoi_cmd),
        .eoi_level                (eoi_level),
        .rotate_on_eoi            (rotate_on_eoi),
        .set_priority             (set_priority),
        .priority_level           (priority_level),
        .auto_eoi_mode            (auto_eoi_mode),
        .end_of_ack               (end_of_ack),
        .special_mask_mode        (special_mask_mode),
        .interrupt_special_mask   (interrupt_special_mask),
        .in_service_register      (in_service_register),
        .lowest_priority          (lowest_priority),
        .highest_level_in_service (highest_level_in_service),
        .highest_level_id         (highest_level_id),
        .in_service_valid         (in_service_valid)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       latch;
        logic [7:0] intr;
        logic [1:0] cmd;
        logic [2:0] lvl;
        logic       rot;
        logic       setp;
        logic [2:0] plev;
        logic       aeoi;
        logic       eoa;
        logic       smm;
        logic [7:0] smask;
        logic [7:0] e_isr;
        logic [2:0] e_lp;
        logic [2:0] e_hid;
        logic       e_valid;
    } vec_t;

    vec_t tbl [22];

    // reference model state
    logic [7:0] m_isr;
    logic [7:0] m_ll;
    int         m_lp;

    function automatic vec_t mk(input int latch, input int intr, input int cmd, input int lvl,
                                input int rot, input int setp, input int plev, input int aeoi,
                                input int eoa, input int smm, input int smask, input int e_isr,
                                input int e_lp, input int e_hid, input int e_valid);
        vec_t v;
        v.latch = latch[0];   v.intr = intr[7:0];   v.cmd = cmd[1:0];   v.lvl = lvl[2:0];
        v.rot = rot[0];       v.setp = setp[0];     v.plev = plev[2:0]; v.aeoi = aeoi[0];
        v.eoa = eoa[0];       v.smm = smm[0];       v.smask = smask[7:0];
        v.e_isr = e_isr[7:0]; v.e_lp = e_lp[2:0];   v.e_hid = e_hid[2:0]; v.e_valid = e_valid[0];
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        latch_in_service       = v.latch;
        interrupt              = v.intr;
        eoi_cmd                = v.cmd;
        eoi_level              = v.lvl;
        rotate_on_eoi          = v.rot;
        set_priority           = v.setp;
        priority_level         = v.plev;
        auto_eoi_mode          = v.aeoi;
        end_of_ack             = v.eoa;
        special_mask_mode      = v.smm;
        interrupt_special_mask = v.smask;
    endtask

    task automatic check_outputs(input string tag, input int e_isr, input int e_lp,
                                 input int e_hid, input int e_valid);
        chk({tag, " isr"}, int'(in_service_register), e_isr);
        chk({tag, " lowest"}, int'(lowest_priority), e_lp);
        chk({tag, " hid"}, int'(highest_level_id), e_hid);
        chk({tag, " valid"}, int'(in_service_valid), e_valid);
        chk({tag, " onehot"}, int'(highest_level_in_service), e_valid != 0 ? (1 << e_hid) : 0);
    endtask

    // highest-priority set level of s when level lp is the lowest; -1 if none
    function automatic int m_highest(input logic [7:0] s, input int lp);
        for (int k = 1; k <= N; k++) begin
            int p;
            p = (lp + k) % N;
            if (s[p]) return p;
        end
        return -1;
    endfunction

    // advance the reference model by one clock edge using the inputs now applied
    task automatic model_step();
        logic [7:0] s, c;
        int h, new_lp, low;
        bit auto_fire;
        s = special_mask_mode ? (m_isr & ~interrupt_special_mask) : m_isr;
        h = m_highest(s, m_lp);
        c = 8'h00;
        new_lp = m_lp;
        auto_fire = auto_eoi_mode && end_of_ack && (m_ll != 8'h00);
        low = 0;
        for (int i = N - 1; i >= 0; i--) if (m_ll[i]) low = i;
        if (eoi_cmd == 2'b01 && h >= 0) c[h] = 1'b1;
        if (eoi_cmd == 2'b10) c[eoi_level] = 1'b1;
        if (auto_fire) c = c | m_ll;
        if (set_priority) new_lp = int'(priority_level);
        else if (rotate_on_eoi) begin
            if (eoi_cmd == 2'b01 && h >= 0) new_lp = h;
            else if (eoi_cmd == 2'b10) new_lp = int'(eoi_level);
            else if (auto_fire) new_lp = low;
        end
        m_isr = (m_isr & ~c) | (latch_in_service ? interrupt : 8'h00);
        if (latch_in_service) m_ll = interrupt;
        else if (auto_fire) m_ll = 8'h00;
        m_lp = new_lp;
    endtask

    task automatic model_check();
        logic [7:0] s;
        int h;
        s = special_mask_mode ? (m_isr & ~interrupt_special_mask) : m_isr;
        h = m_highest(s, m_lp);
        check_outputs("rand", int'(m_isr), m_lp, h < 0 ? 0 : h, h < 0 ? 0 : 1);
    endtask

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        //            latch intr  cmd lvl rot setp plev aeoi eoa smm smask   isr  lp hid val
        tbl[0]  = mk(1, 8'h08, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h08, 7, 3, 1);
        tbl[1]  = mk(1, 8'h02, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h0A, 7, 1, 1);
        tbl[2]  = mk(0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h08, 1, 3, 1);
        tbl[3]  = mk(0, 8'h00, 0, 0, 0, 1, 4, 0, 0, 0, 8'h00, 8'h08, 4, 3, 1);
        tbl[4]  = mk(0, 8'h00, 2, 3, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 4, 0, 0);
        tbl[5]  = mk(1, 8'h21, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h21, 4, 5, 1);
        tbl[6]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 8'h20, 8'h21, 4, 0, 1);
        tbl[7]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 8'h21, 8'h21, 4, 0, 0);
        tbl[8]  = mk(0, 8'h00, 2, 5, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01, 4, 0, 1);
        tbl[9]  = mk(0, 8'h00, 2, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        tbl[10] = mk(1, 8'h04, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h04, 0, 2, 1);
        tbl[11] = mk(1, 8'h04, 2, 2, 0, 0, 0, 0, 0, 0, 8'h00, 8'h04, 0, 2, 1);
        tbl[12] = mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        tbl[13] = mk(0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        tbl[14] = mk(1, 8'h10, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h10, 0, 4, 1);
        tbl[15] = mk(0, 8'h00, 3, 4, 1, 0, 0, 0, 0, 0, 8'h00, 8'h10, 0, 4, 1);
        tbl[16] = mk(0, 8'h00, 2, 1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h10, 1, 4, 1);
        tbl[17] = mk(0, 8'h00, 2, 4, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
        tbl[18] = mk(1, 8'h40, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h40, 1, 6, 1);
        tbl[19] = mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 1, 0, 8'h00, 8'h00, 6, 0, 0);
        tbl[20] = mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 1, 0, 8'h00, 8'h00, 6, 0, 0);
        tbl[21] = mk(1, 8'h80, 2, 3, 1, 1, 2, 0, 0, 0, 8'h00, 8'h80, 2, 7, 1);

        reset_n = 1'b0;
        drive(idle);
        repeat (2) @(posedge clock);
        #1;
        check_outputs("reset", 0, 7, 0, 0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i]);
            @(posedge clock);
            #1;
            check_outputs($sformatf("vec%0d", i), int'(tbl[i].e_isr), int'(tbl[i].e_lp),
                          int'(tbl[i].e_hid), int'(tbl[i].e_valid));
        end

        // fill ISR and move the pointer, then pull reset in the middle of a cycle
        drive(mk(1, 8'hFF, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clock);
        #1;
        check_outputs("fill", 8'hFF, 2, 3, 1);
        drive(idle);
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs("async_reset", 0, 7, 0, 0);
        @(posedge clock);
        #1;
        check_outputs("held_reset", 0, 7, 0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        drive(mk(1, 8'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clock);
        #1;
        check_outputs("post_reset", 8'h01, 7, 0, 1);

        // random phase from a clean reset
        drive(idle);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        m_isr = 8'h00;
        m_ll  = 8'h00;
        m_lp  = 7;
        for (int n = 0; n < 400; n++) begin
            latch_in_service       = ($urandom_range(0, 2) == 0);
            interrupt              = ($urandom_range(0, 4) == 0) ? 8'($urandom) : (8'h01 << $urandom_range(0, 7));
            eoi_cmd                = 2'($urandom_range(0, 3));
            eoi_level              = 3'($urandom_range(0, 7));
            rotate_on_eoi          = 1'($urandom_range(0, 1));
            set_priority           = ($urandom_range(0, 9) == 0);
            priority_level         = 3'($urandom_range(0, 7));
            auto_eoi_mode          = 1'($urandom_range(0, 1));
            end_of_ack             = latch_in_service ? 1'b0 : 1'($urandom_range(0, 1));
            special_mask_mode      = ($urandom_range(0, 3) == 0);
            interrupt_special_mask = 8'($urandom);
            model_step();
            @(posedge clock);
            #1;
            model_check();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
